// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared types, default constants and helpers for the synthesizer voice path.
//   env_state_t  : ADSR envelope states
//   *_DEF        : default widths and envelope step constants
//   vel_to_peak  : 7-bit velocity replicated MSB-first into a 32-bit word;
//                  callers keep the top bits they need as the peak level
// -----------------------------------------------------------------------------
package synth_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

   localparam int DATA_WDTH_DEF     = 24;
   localparam int ENV_WDTH_DEF      = 16;
   localparam int ATTACK_STEP_DEF   = 1024;
   localparam int DECAY_STEP_DEF    = 256;
   localparam int SUSTAIN_SHIFT_DEF = 1;
   localparam int RELEASE_STEP_DEF  = 128;
   localparam int RELEASE_SHIFT_DEF = 8;

   // Repeating the velocity bit pattern makes full velocity map to all ones
   // and spreads the remaining codes evenly over the level range.
   function automatic logic [31:0] vel_to_peak(input logic [6:0] vel);
      logic [31:0] rep;
      rep = 32'd0;
      for (int i = 0; i < 32; i++) begin
         rep[31 - i] = vel[6 - (i % 7)];
      end
      return rep;
   endfunction

endpackage

// File: rtl/env_scaler.sv
// -----------------------------------------------------------------------------
// env_scaler
// Registered signed-sample x unsigned-gain multiply, scaled back by the gain
// width. Output reflects the inputs of the previous clock (1-cycle latency).
//   clk, rst_n : clock, asynchronous active-low reset
//   i_sample   : signed sample, DATA_WDTH bits
//   i_gain     : unsigned gain, ENV_WDTH bits (full scale = 2^ENV_WDTH)
//   o_sample   : signed scaled sample, DATA_WDTH bits
// -----------------------------------------------------------------------------
module env_scaler
   import synth_pkg::*;
#(
   parameter int DATA_WDTH = DATA_WDTH_DEF,
   parameter int ENV_WDTH  = ENV_WDTH_DEF
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [DATA_WDTH-1:0] i_sample,
   input  logic        [ENV_WDTH-1:0]  i_gain,
   output logic signed [DATA_WDTH-1:0] o_sample
);

   localparam int PROD_WDTH = DATA_WDTH + ENV_WDTH + 1;

   logic signed [PROD_WDTH-1:0] w_a;
   logic signed [PROD_WDTH-1:0] w_b;
   logic signed [PROD_WDTH-1:0] w_prod;
   logic                        w_unused;

   // Gain gets a zero sign bit so the multiply stays signed x unsigned.
   assign w_a    = {{(ENV_WDTH + 1){i_sample[DATA_WDTH-1]}}, i_sample};
   assign w_b    = {{DATA_WDTH{1'b0}}, 1'b0, i_gain};
   assign w_prod = w_a * w_b;

   // Fraction bits and the redundant sign bit are dropped; gain < 2^ENV_WDTH
   // so the kept slice cannot overflow.
   assign w_unused = ^{w_prod[ENV_WDTH-1:0], w_prod[PROD_WDTH-1]};

   // Arithmetic shift right by ENV_WDTH then truncate == take this slice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_sample <= {DATA_WDTH{1'b0}};
      end else begin
         o_sample <= w_prod[ENV_WDTH +: DATA_WDTH];
      end
   end

endmodule

// File: rtl/envelope_gen.sv
// -----------------------------------------------------------------------------
// envelope_gen
// Per-voice ADSR amplitude envelope. The envelope advances once per sample
// on the load strobe; the dds sample is scaled by the current level.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : one-cycle sample strobe; gate/note/velocity sampled only here
//   note       : voice note (0 = no note)
//   velocity   : voice velocity (0 = note-off)
//   sine_in    : signed dds sample
//   sample_out : enveloped sample, one clock after sine_in/env_level
//   env_level  : current envelope level
//   active     : high whenever the envelope is not IDLE
// Optional build macro ENV_EXP_RELEASE_EN: exponential release
// (decrement = max(level >> RELEASE_SHIFT, 1)) instead of linear RELEASE_STEP.
// -----------------------------------------------------------------------------
module envelope_gen
   import synth_pkg::*;
#(
   parameter int DATA_WDTH     = DATA_WDTH_DEF,
   parameter int ENV_WDTH      = ENV_WDTH_DEF,
   parameter int ATTACK_STEP   = ATTACK_STEP_DEF,
   parameter int DECAY_STEP    = DECAY_STEP_DEF,
   parameter int SUSTAIN_SHIFT = SUSTAIN_SHIFT_DEF,
   parameter int RELEASE_STEP  = RELEASE_STEP_DEF,
   parameter int RELEASE_SHIFT = RELEASE_SHIFT_DEF
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load,
   input  logic        [6:0]           note,
   input  logic        [6:0]           velocity,
   input  logic signed [DATA_WDTH-1:0] sine_in,
   output logic signed [DATA_WDTH-1:0] sample_out,
   output logic        [ENV_WDTH-1:0]  env_level,
   output logic                        active
);

   localparam logic        [ENV_WDTH:0]   ATK_STEP_W = (ENV_WDTH + 1)'(ATTACK_STEP);
   localparam logic signed [ENV_WDTH+1:0] DEC_STEP_W = (ENV_WDTH + 2)'(DECAY_STEP);

   env_state_t                 r_state;
   logic        [ENV_WDTH-1:0] r_level;
   logic        [ENV_WDTH-1:0] r_peak;
   logic        [6:0]          r_note;
   logic                       r_active;

   logic                       w_gate;
   logic                       w_enter;
   logic        [31:0]         w_vel_rep;
   logic        [ENV_WDTH-1:0] w_new_peak;
   logic        [ENV_WDTH-1:0] w_sustain;
   logic        [ENV_WDTH:0]   w_atk_sum;
   logic        [ENV_WDTH-1:0] w_entry_level;
   logic signed [ENV_WDTH+1:0] w_dec_diff;
   logic signed [ENV_WDTH+1:0] w_sus_ext;
   logic        [ENV_WDTH-1:0] w_rel_dec;
   logic                       w_unused;

   assign w_gate     = (note != 7'd0) && (velocity != 7'd0);
   assign w_vel_rep  = vel_to_peak(velocity);
   assign w_new_peak = w_vel_rep[31 -: ENV_WDTH];
   assign w_sustain  = r_peak >> SUSTAIN_SHIFT;
   assign w_atk_sum  = {1'b0, r_level} + ATK_STEP_W;
   assign w_dec_diff = $signed({2'b00, r_level}) - DEC_STEP_W;
   assign w_sus_ext  = $signed({2'b00, w_sustain});

   // On (re)entry to ATTACK the level keeps its value and takes one attack
   // step toward the new peak, never overshooting it.
   assign w_entry_level = (w_atk_sum >= {1'b0, w_new_peak}) ? w_new_peak
                                                            : w_atk_sum[ENV_WDTH-1:0];

`ifdef ENV_EXP_RELEASE_EN
   logic [ENV_WDTH-1:0] w_rel_shift;
   assign w_rel_shift = r_level >> RELEASE_SHIFT;
   assign w_unused    = ^{w_vel_rep, 32'(RELEASE_STEP)};

   // Exponential release: proportional step, at least 1 so it always ends.
   always_comb begin
      w_rel_dec = ENV_WDTH'(0);
      if (w_rel_shift == ENV_WDTH'(0)) begin
         w_rel_dec = ENV_WDTH'(1);
      end else begin
         w_rel_dec = w_rel_shift;
      end
   end
`else
   assign w_rel_dec = ENV_WDTH'(RELEASE_STEP);
   assign w_unused  = ^{w_vel_rep, 32'(RELEASE_SHIFT)};
`endif

   // Note-on from rest, or a new note while sounding, restarts the attack.
   always_comb begin
      w_enter = 1'b0;
      case (r_state)
         IDLE, RELEASE:           w_enter = w_gate;
         ATTACK, DECAY, SUSTAIN:  w_enter = w_gate && (note != r_note);
         default:                 w_enter = 1'b0;
      endcase
   end

   // Envelope FSM: state, level, latched note/peak and active flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_level  <= ENV_WDTH'(0);
         r_peak   <= ENV_WDTH'(0);
         r_note   <= 7'd0;
         r_active <= 1'b0;
      end else if (load) begin
         if (w_enter) begin
            r_state  <= ATTACK;
            r_peak   <= w_new_peak;
            r_note   <= note;
            r_level  <= w_entry_level;
            r_active <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  r_level  <= ENV_WDTH'(0);
                  r_active <= 1'b0;
               end
               ATTACK: begin
                  if (!w_gate) begin
                     r_state <= RELEASE;
                  end else if (w_atk_sum >= {1'b0, r_peak}) begin
                     // also covers a level left above a lower retrigger peak
                     r_level <= r_peak;
                     r_state <= DECAY;
                  end else begin
                     r_level <= w_atk_sum[ENV_WDTH-1:0];
                  end
               end
               DECAY: begin
                  if (!w_gate) begin
                     r_state <= RELEASE;
                  end else if (w_dec_diff <= w_sus_ext) begin
                     r_level <= w_sustain;
                     r_state <= SUSTAIN;
                  end else begin
                     r_level <= w_dec_diff[ENV_WDTH-1:0];
                  end
               end
               SUSTAIN: begin
                  if (!w_gate) begin
                     r_state <= RELEASE;
                  end
               end
               RELEASE: begin
                  if (r_level <= w_rel_dec) begin
                     r_level  <= ENV_WDTH'(0);
                     r_state  <= IDLE;
                     r_active <= 1'b0;
                  end else begin
                     r_level <= r_level - w_rel_dec;
                  end
               end
               default: begin
                  r_state  <= IDLE;
                  r_level  <= ENV_WDTH'(0);
                  r_active <= 1'b0;
               end
            endcase
         end
      end
   end

   assign env_level = r_level;
   assign active    = r_active;

   env_scaler #(
      .DATA_WDTH (DATA_WDTH),
      .ENV_WDTH  (ENV_WDTH)
   ) u_scaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sample (sine_in),
      .i_gain   (r_level),
      .o_sample (sample_out)
   );

endmodule
